// File: rtl/writeback_arbiter_if.sv
// Shared writeback types and the AXI-Stream style handshake interface
// that carries them into the writeback arbiter.

package core;

    typedef logic [4:0]  addr_t;
    typedef logic [31:0] word_t;

    typedef struct packed {
        logic rd;
    } wb_ctrl_t;

    typedef struct packed {
        addr_t addr;
        word_t data;
    } wb_rd_t;

    typedef struct packed {
        wb_rd_t rd;
    } wb_data_t;

    typedef struct packed {
        wb_ctrl_t ctrl;
        wb_data_t data;
    } wb_t;

endpackage

interface axis;

    logic      tvalid;
    logic      tready;
    core::wb_t tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);

endinterface

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: shares the single register-file write port between
// the integer pipeline (up0) and the long-latency unit (up1). Round-robin
// on contention, one beat accepted per cycle, registered output stage.

module writeback_arbiter (
    input  logic        clk,
    input  logic        reset,
    axis.slave          up0,
    axis.slave          up1,
    output logic        rd,
    output core::addr_t rd_addr,
    output core::word_t rd_data,
    output logic [1:0]  grant
);

    logic        last_r;
    logic        sel_valid_s;
    logic        sel_idx_s;
    core::wb_t   beat_s;
    logic        wen_s;
    logic        rd_r;
    core::addr_t rd_addr_r;
    core::word_t rd_data_r;
    logic [1:0]  grant_r;

    // Source selection from both tvalids and last; nothing is accepted in reset.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_idx_s   = 1'b0;
        if (reset) begin
            sel_valid_s = 1'b0;
            sel_idx_s   = 1'b0;
        end else if (up0.tvalid && up1.tvalid) begin
            sel_valid_s = 1'b1;
            sel_idx_s   = ~last_r;
        end else if (up0.tvalid) begin
            sel_valid_s = 1'b1;
            sel_idx_s   = 1'b0;
        end else if (up1.tvalid) begin
            sel_valid_s = 1'b1;
            sel_idx_s   = 1'b1;
        end else begin
            sel_valid_s = 1'b0;
            sel_idx_s   = 1'b0;
        end
    end

    // Mux the selected beat and decide whether it actually writes a register.
    always_comb begin
        beat_s = up0.tdata;
        if (sel_idx_s) begin
            beat_s = up1.tdata;
        end else begin
            beat_s = up0.tdata;
        end
        wen_s = sel_valid_s && beat_s.ctrl.rd && (beat_s.data.rd.addr != 5'd0);
    end

    // tready depends only on the tvalids and last, never on tdata.
    assign up0.tready = sel_valid_s & ~sel_idx_s;
    assign up1.tready = sel_valid_s &  sel_idx_s;

    // Round-robin pointer: follows every handshake, source 0 wins first after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_r <= 1'b1;
        end else if (sel_valid_s) begin
            last_r <= sel_idx_s;
        end else begin
            last_r <= last_r;
        end
    end

    // Write strobe and grant pulse for exactly one cycle per enabled beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_r    <= 1'b0;
            grant_r <= 2'b00;
        end else if (wen_s) begin
            rd_r    <= 1'b1;
            grant_r <= sel_idx_s ? 2'b10 : 2'b01;
        end else begin
            rd_r    <= 1'b0;
            grant_r <= 2'b00;
        end
    end

    // Address/data only load on an enabled write and hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_addr_r <= 5'd0;
            rd_data_r <= 32'd0;
        end else if (wen_s) begin
            rd_addr_r <= beat_s.data.rd.addr;
            rd_data_r <= beat_s.data.rd.data;
        end else begin
            rd_addr_r <= rd_addr_r;
            rd_data_r <= rd_data_r;
        end
    end

    assign rd      = rd_r;
    assign rd_addr = rd_addr_r;
    assign rd_data = rd_data_r;
    assign grant   = grant_r;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter.

module tb_writeback_arbiter;

    logic        clk;
    logic        reset;
    logic        rd;
    core::addr_t rd_addr;
    core::word_t rd_data;
    logic [1:0]  grant;

    int checks;
    int failures;

    axis up0_if ();
    axis up1_if ();

    writeback_arbiter dut (
        .clk     (clk),
        .reset   (reset),
        .up0     (up0_if),
        .up1     (up1_if),
        .rd      (rd),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .grant   (grant)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic core::wb_t mk(input logic wr, input logic [4:0] addr, input logic [31:0] data);
        core::wb_t w;
        w.ctrl.rd       = wr;
        w.data.rd.addr  = addr;
        w.data.rd.data  = data;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        up0_if.tvalid = 1'b0;
        up1_if.tvalid = 1'b0;
    endtask

    logic [4:0]  exp_addr [8];
    logic [1:0]  exp_grant [8];
    int i0;
    int i1;

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        up0_if.tvalid = 1'b0;
        up1_if.tvalid = 1'b0;
        up0_if.tdata  = mk(1'b0, 5'd0, 32'd0);
        up1_if.tdata  = mk(1'b0, 5'd0, 32'd0);

        // Reset state, with both sources valid to show tready is gated.
        #2;
        up0_if.tvalid = 1'b1;
        up0_if.tdata  = mk(1'b1, 5'd6, 32'h66);
        up1_if.tvalid = 1'b1;
        up1_if.tdata  = mk(1'b1, 5'd16, 32'h16);
        #1;
        check_eq("rst_rd",      {63'd0, rd}, 64'd0);
        check_eq("rst_addr",    {59'd0, rd_addr}, 64'd0);
        check_eq("rst_data",    {32'd0, rd_data}, 64'd0);
        check_eq("rst_grant",   {62'd0, grant}, 64'd0);
        check_eq("rst_tready0", {63'd0, up0_if.tready}, 64'd0);
        check_eq("rst_tready1", {63'd0, up1_if.tready}, 64'd0);
        tick();
        check_eq("rst_edge_rd", {63'd0, rd}, 64'd0);
        idle();
        @(negedge clk);
        reset = 1'b0;

        // Contention right after reset: 1,11,2,12,3,13,4,14 alternating.
        exp_addr  = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13, 5'd4, 5'd14};
        exp_grant = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        i0 = 0;
        i1 = 0;
        for (int c = 0; c < 8; c++) begin
            up0_if.tvalid = (i0 < 4);
            up0_if.tdata  = mk(1'b1, 5'(i0 + 1), 32'h100 + 32'(i0));
            up1_if.tvalid = (i1 < 4);
            up1_if.tdata  = mk(1'b1, 5'(i1 + 11), 32'h200 + 32'(i1));
            #1;
            if (up0_if.tvalid && up0_if.tready) i0++;
            if (up1_if.tvalid && up1_if.tready) i1++;
            tick();
            check_eq($sformatf("cont_rd%0d", c),    {63'd0, rd}, 64'd1);
            check_eq($sformatf("cont_addr%0d", c),  {59'd0, rd_addr}, {59'd0, exp_addr[c]});
            check_eq($sformatf("cont_grant%0d", c), {62'd0, grant}, {62'd0, exp_grant[c]});
        end
        check_eq("cont_last_data", {32'd0, rd_data}, 64'h203);
        idle();

        // Same destination on both sources, last=1 -> up0 first then up1.
        up0_if.tvalid = 1'b1;
        up0_if.tdata  = mk(1'b1, 5'd9, 32'hA);
        up1_if.tvalid = 1'b1;
        up1_if.tdata  = mk(1'b1, 5'd9, 32'hB);
        #1;
        check_eq("same_tready0", {63'd0, up0_if.tready}, 64'd1);
        check_eq("same_tready1", {63'd0, up1_if.tready}, 64'd0);
        tick();
        check_eq("same_data1",  {32'd0, rd_data}, 64'hA);
        check_eq("same_grant1", {62'd0, grant}, 64'd1);
        up0_if.tvalid = 1'b0;
        tick();
        check_eq("same_rd2",    {63'd0, rd}, 64'd1);
        check_eq("same_data2",  {32'd0, rd_data}, 64'hB);
        check_eq("same_grant2", {62'd0, grant}, 64'd2);
        idle();

        // Suppressed beats: x0 destination, then ctrl.rd = 0.
        up1_if.tvalid = 1'b1;
        up1_if.tdata  = mk(1'b1, 5'd0, 32'h1);
        #1;
        check_eq("sup_tready_a", {63'd0, up1_if.tready}, 64'd1);
        tick();
        check_eq("sup_rd_a",    {63'd0, rd}, 64'd0);
        check_eq("sup_grant_a", {62'd0, grant}, 64'd0);
        check_eq("sup_addr_a",  {59'd0, rd_addr}, 64'd9);
        up1_if.tdata  = mk(1'b0, 5'd7, 32'h2);
        #1;
        check_eq("sup_tready_b", {63'd0, up1_if.tready}, 64'd1);
        tick();
        check_eq("sup_rd_b",   {63'd0, rd}, 64'd0);
        check_eq("sup_addr_b", {59'd0, rd_addr}, 64'd9);
        check_eq("sup_data_b", {32'd0, rd_data}, 64'hB);
        idle();

        // Single source write, then hold.
        up0_if.tvalid = 1'b1;
        up0_if.tdata  = mk(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        check_eq("single_rd",    {63'd0, rd}, 64'd1);
        check_eq("single_addr",  {59'd0, rd_addr}, 64'd5);
        check_eq("single_data",  {32'd0, rd_data}, 64'hDEADBEEF);
        check_eq("single_grant", {62'd0, grant}, 64'd1);
        idle();
        tick();
        check_eq("hold_rd",    {63'd0, rd}, 64'd0);
        check_eq("hold_addr",  {59'd0, rd_addr}, 64'd5);
        check_eq("hold_grant", {62'd0, grant}, 64'd0);

        // Reset mid-stream while up1 is valid and granted.
        up1_if.tvalid = 1'b1;
        up1_if.tdata  = mk(1'b1, 5'd3, 32'h33);
        tick();
        check_eq("mid_pre_rd",    {63'd0, rd}, 64'd1);
        check_eq("mid_pre_grant", {62'd0, grant}, 64'd2);
        up1_if.tdata  = mk(1'b1, 5'd4, 32'h44);
        #1;
        check_eq("mid_pre_tready1", {63'd0, up1_if.tready}, 64'd1);
        #1;
        reset = 1'b1;
        #1;
        check_eq("mid_rd",      {63'd0, rd}, 64'd0);
        check_eq("mid_grant",   {62'd0, grant}, 64'd0);
        check_eq("mid_addr",    {59'd0, rd_addr}, 64'd0);
        check_eq("mid_tready1", {63'd0, up1_if.tready}, 64'd0);
        tick();
        check_eq("mid_edge_rd", {63'd0, rd}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        up0_if.tvalid = 1'b1;
        up0_if.tdata  = mk(1'b1, 5'd20, 32'h20);
        #1;
        check_eq("post_tready0", {63'd0, up0_if.tready}, 64'd1);
        check_eq("post_tready1", {63'd0, up1_if.tready}, 64'd0);
        tick();
        check_eq("post_rd",    {63'd0, rd}, 64'd1);
        check_eq("post_addr",  {59'd0, rd_addr}, 64'd20);
        check_eq("post_grant", {62'd0, grant}, 64'd1);
        up0_if.tvalid = 1'b0;
        tick();
        check_eq("post2_addr",  {59'd0, rd_addr}, 64'd4);
        check_eq("post2_data",  {32'd0, rd_data}, 64'h44);
        check_eq("post2_grant", {62'd0, grant}, 64'd2);
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
